// File: rtl/serial_comp_fsm.sv
// Bit-serial LSB-first 1's/2's complementer over WIDTH-bit frames, 1-cycle latency.
// Optional overflow flag on the last bit is enabled with SERIAL_COMP_OVF_EN.
module serial_comp_fsm #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic in_valid,
  input  logic in_data,
  output logic out_valid,
  output logic out_data,
  output logic out_last,
  output logic busy
`ifdef SERIAL_COMP_OVF_EN
  ,
  output logic out_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONES = 2'd1,
    PASS = 2'd2,
    INV  = 2'd3
  } state_t;

  state_t             state_q, state_d, eff_state;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d, eff_mode;
  logic               out_valid_q, out_valid_d;
  logic               out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_ovf_q, out_ovf_d;
  logic               last_bit;
  logic               pass_bit;

  // Handshake: a bit is consumed on every cycle in_valid=1 (no backpressure);
  // its result appears one cycle later qualified by out_valid.
  always_comb begin
    eff_mode    = (state_q == IDLE) ? mode : mode_q;
    eff_state   = (state_q == IDLE) ? (mode ? PASS : ONES) : state_q;
    last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
    pass_bit    = eff_mode && (eff_state == PASS);
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    out_ovf_d   = 1'b0;
    if (in_valid) begin
      mode_d     = eff_mode;
      out_data_d = pass_bit ? in_data : ~in_data;
      out_last_d = last_bit;
      out_ovf_d  = last_bit && pass_bit && in_data;
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = (pass_bit && in_data) ? INV : eff_state;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

`ifdef SERIAL_COMP_OVF_EN
  assign out_ovf = out_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = out_ovf_q;
`endif

endmodule

// File: tb/tb_serial_comp_fsm.sv
// Self-checking bench for serial_comp_fsm: word-level arithmetic model checked every cycle,
// plus literal expectations on whole output frames.
module tb_serial_comp_fsm;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_data = 1'b0;
  logic out_valid, out_data, out_last, busy;
`ifdef SERIAL_COMP_OVF_EN
  logic out_ovf;
`endif

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  serial_comp_fsm #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef SERIAL_COMP_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: each output bit is bit idx of ~word or -word over the bits seen so far
  int             idx = 0;
  logic           frame_mode = 1'b0;
  logic [W-1:0]   acc = '0;
  logic [W-1:0]   neg;
  logic           exp_valid = 1'b0, exp_data = 1'b0, exp_last = 1'b0, exp_busy = 1'b0, exp_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      idx = 0; acc = '0;
      exp_valid = 0; exp_data = 0; exp_last = 0; exp_busy = 0; exp_ovf = 0;
    end else if (in_valid) begin
      if (idx == 0) begin
        frame_mode = mode;
        acc = '0;
      end
      acc[idx] = in_data;
      neg = -acc;
      exp_valid = 1;
      exp_data  = frame_mode ? neg[idx] : ~in_data;
      exp_last  = (idx == W - 1);
      exp_ovf   = exp_last && frame_mode && (acc == (W'(1) << (W - 1)));
      idx       = exp_last ? 0 : idx + 1;
      exp_busy  = (idx != 0);
    end else begin
      exp_valid = 0; exp_last = 0; exp_ovf = 0;
      exp_busy  = (idx != 0);
    end
  end

  // scoreboard: literal frame results pushed by directed tests, collected words compared at the end
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] part = '0;
  int           part_n = 0;
  bit           collect_en = 1'b0;

  always @(posedge clk) begin
    #1;
    chk("out_valid", W'(out_valid), W'(exp_valid));
    chk("out_data",  W'(out_data),  W'(exp_data));
    chk("out_last",  W'(out_last),  W'(exp_last));
    chk("busy",      W'(busy),      W'(exp_busy));
`ifdef SERIAL_COMP_OVF_EN
    chk("out_ovf",   W'(out_ovf),   W'(exp_ovf));
`endif
    if (rst) begin
      part = '0; part_n = 0;
    end else if (out_valid) begin
      part[part_n] = out_data;
      part_n++;
      if (out_last) begin
        if (collect_en) got_q.push_back(part);
        part = '0; part_n = 0;
      end
    end
  end

  // driver tasks
  task automatic send_bit(input logic b, input logic m);
    @(negedge clk);
    in_valid = 1'b1; in_data = b; mode = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_data = $urandom_range(0, 1);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic m, input bit toggle,
                            input int gap_after, input int gap_len);
    for (int i = 0; i < W; i++) begin
      send_bit(w[i], (toggle && i > 0) ? ~m : m);
      if (i == gap_after) idle(gap_len);
    end
  endtask

  task automatic pulse_rst;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // 1) reset held 2 cycles with in_valid high
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_busy",      W'(busy),      '0);
    chk("rst_out_last",  W'(out_last),  '0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    collect_en = 1'b1;

    // 2) 1's complement, continuous
    exp_q.push_back(8'hA5);
    send_frame(8'h5A, 1'b0, 1'b0, -1, 0);
    // 3) 2's complement back-to-back, 0x80 is the overflow case
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'h80);
    send_frame(8'h06, 1'b1, 1'b0, -1, 0);
    send_frame(8'h80, 1'b1, 1'b0, -1, 0);
    idle(2);
    // 4) zero, then mode toggled mid-frame
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b0, -1, 0);
    exp_q.push_back(8'hFA);
    send_frame(8'h06, 1'b1, 1'b1, -1, 0);
    idle(1);
    // 5) gap of 3 cycles between bits 2 and 3
    exp_q.push_back(8'hF4);
    send_frame(8'h0C, 1'b1, 1'b0, 2, 3);
    idle(1);
    // 6) reset after bit 4, then a clean frame
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    pulse_rst();
    exp_q.push_back(8'hFF);
    send_frame(8'h01, 1'b1, 1'b0, -1, 0);
    idle(3);
    collect_en = 1'b0;

    // randomized frames with gaps, mid-frame mode noise and occasional resets
    for (int f = 0; f < 150; f++) begin
      logic [W-1:0] w;
      logic m;
      w = W'($urandom);
      if ($urandom_range(0, 7) == 0) w = W'(1) << (W - 1);
      m = $urandom_range(0, 1);
      for (int i = 0; i < W; i++) begin
        send_bit(w[i], (i == 0) ? m : logic'($urandom_range(0, 1)));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 60) == 0) begin
          pulse_rst();
          break;
        end
      end
    end
    idle(3);

    chk("frame_count", W'(got_q.size()), W'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("frame_word", got_q.pop_front(), exp_q.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
